// File: rtl/segment_led_scanner.sv
// Multiplexed 7-segment/LED scanner: per-digit time slots with a ghost-suppression
// blank, PWM brightness, and a double-buffered display image swapped at frame boundaries.
module segment_led_scanner #(
  parameter int NUMBER_OF_SEGMENTS = 8,
  parameter int NUMBER_OF_DIGITS   = 4,
  parameter int SEGMENT_ACTIVE_LOW = 0,
  parameter int DIGIT_ACTIVE_LOW   = 1,
  parameter int SCAN_DIVIDER       = 1024,
  parameter int BLANK_CYCLES       = 16,
  parameter int BRIGHTNESS_BITS    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUMBER_OF_SEGMENTS-1:0] digits [0:NUMBER_OF_DIGITS-1],
  input  logic [NUMBER_OF_DIGITS-1:0]   digit_enable,
  input  logic                          update_valid,
  output logic                          update_ready,
  input  logic [BRIGHTNESS_BITS-1:0]    brightness,
  output logic [NUMBER_OF_SEGMENTS-1:0] segment_out,
  output logic [NUMBER_OF_DIGITS-1:0]   digit_selector_out,
  output logic                          frame_done
);

  localparam int SLOT_W  = (SCAN_DIVIDER > 1) ? $clog2(SCAN_DIVIDER) : 1;
  localparam int IDX_W   = $clog2(NUMBER_OF_DIGITS);
  localparam int PHASE_W = (SLOT_W > BRIGHTNESS_BITS) ? SLOT_W : BRIGHTNESS_BITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIVIDER - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUMBER_OF_DIGITS - 1);

  localparam logic [NUMBER_OF_SEGMENTS-1:0] SEG_POL =
    {NUMBER_OF_SEGMENTS{(SEGMENT_ACTIVE_LOW != 0)}};
  localparam logic [NUMBER_OF_DIGITS-1:0] DIG_POL =
    {NUMBER_OF_DIGITS{(DIGIT_ACTIVE_LOW != 0)}};

  logic [SLOT_W-1:0]             slot_count;
  logic [IDX_W-1:0]              digit_index;
  logic [BRIGHTNESS_BITS-1:0]    brightness_latched;

  logic [NUMBER_OF_SEGMENTS-1:0] active_buf  [0:NUMBER_OF_DIGITS-1];
  logic [NUMBER_OF_DIGITS-1:0]   active_en;
  logic [NUMBER_OF_SEGMENTS-1:0] pending_buf [0:NUMBER_OF_DIGITS-1];
  logic [NUMBER_OF_DIGITS-1:0]   pending_en;
  logic                          pending_flag;
  logic                          ready_q;

  logic                          slot_last;
  logic                          frame_boundary;
  logic [PHASE_W-1:0]            phase_offset;
  logic                          lit_p0;
  logic                          transfer;
  logic                          pending_next;

  logic [NUMBER_OF_SEGMENTS-1:0] segment_p1;
  logic [NUMBER_OF_DIGITS-1:0]   digit_p1;
  logic                          frame_done_p1;

  // Stage p0: slot/phase decode from the current counters
  always_comb begin
    slot_last      = (slot_count == SLOT_LAST);
    frame_boundary = slot_last && (digit_index == IDX_LAST);
    phase_offset   = PHASE_W'(slot_count) - PHASE_W'(BLANK_CYCLES);
    lit_p0         = !(slot_count < BLANK_END)
                     && (phase_offset[BRIGHTNESS_BITS-1:0] < brightness_latched)
                     && active_en[digit_index];
    transfer       = update_valid && ready_q;
    pending_next   = pending_flag;
    if (transfer)
      pending_next = 1'b1;
    else if (frame_boundary && pending_flag)
      pending_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_count  <= '0;
      digit_index <= '0;
    end else if (slot_last) begin
      slot_count  <= '0;
      digit_index <= (digit_index == IDX_LAST) ? '0 : digit_index + IDX_W'(1);
    end else begin
      slot_count  <= slot_count + SLOT_W'(1);
    end
  end

  // Brightness only changes at a slot start so a slot never mixes two duties.
  always_ff @(posedge clock) begin
    if (reset)
      brightness_latched <= '0;
    else if (slot_count == '0)
      brightness_latched <= brightness;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_flag <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      pending_flag <= pending_next;
      ready_q      <= !pending_next;
    end
  end

  always_ff @(posedge clock) begin
    if (transfer) begin
      pending_buf <= digits;
      pending_en  <= digit_enable;
    end
  end

  // A transfer can only happen while nothing is pending, so the copy below
  // never picks up data accepted on the boundary cycle itself.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_DIGITS; i++)
        active_buf[i] <= '0;
      active_en <= '1;
    end else if (frame_boundary && pending_flag) begin
      active_buf <= pending_buf;
      active_en  <= pending_en;
    end
  end

  // Stage p1: registered drive, polarity applied after the register
  always_ff @(posedge clock) begin
    if (reset) begin
      segment_p1    <= '0;
      digit_p1      <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      segment_p1    <= lit_p0 ? active_buf[digit_index] : '0;
      digit_p1      <= lit_p0 ? (NUMBER_OF_DIGITS'(1) << digit_index) : '0;
      frame_done_p1 <= frame_boundary;
    end
  end

  assign segment_out        = segment_p1 ^ SEG_POL;
  assign digit_selector_out = digit_p1 ^ DIG_POL;
  assign frame_done         = frame_done_p1;
  assign update_ready       = ready_q;

endmodule

// File: tb/tb_segment_led_scanner.sv
// Bench for segment_led_scanner: table-driven frames, hand-written handshake/reset
// corner sequences, and random traffic against a time-indexed reference model.
module tb_segment_led_scanner;

  localparam int NS    = 8;
  localparam int ND    = 4;
  localparam int SD    = 32;
  localparam int BL    = 4;
  localparam int BB    = 4;
  localparam int FRAME = SD * ND;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] digits [0:ND-1];
  logic [ND-1:0] digit_enable;
  logic          update_valid;
  logic          update_ready;
  logic [BB-1:0] brightness;
  logic [NS-1:0] segment_out;
  logic [ND-1:0] digit_selector_out;
  logic          frame_done;

  segment_led_scanner #(
    .NUMBER_OF_SEGMENTS(NS),
    .NUMBER_OF_DIGITS  (ND),
    .SEGMENT_ACTIVE_LOW(0),
    .DIGIT_ACTIVE_LOW  (1),
    .SCAN_DIVIDER      (SD),
    .BLANK_CYCLES      (BL),
    .BRIGHTNESS_BITS   (BB)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .digits            (digits),
    .digit_enable      (digit_enable),
    .update_valid      (update_valid),
    .update_ready      (update_ready),
    .brightness        (brightness),
    .segment_out       (segment_out),
    .digit_selector_out(digit_selector_out),
    .frame_done        (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan is the cycle count since reset.
  int          t;
  logic [7:0]  m_act  [4];
  logic [7:0]  m_pbuf [4];
  logic [3:0]  m_en, m_pen;
  logic        m_pend, m_ready;
  int          m_bl;

  logic [7:0]  obs_seg;
  logic [3:0]  obs_dig;
  logic        obs_fd, obs_rdy;

  typedef struct {
    logic [3:0][7:0] pat;
    logic [3:0]      en;
    logic [3:0]      br;
    logic [3:0][7:0] exp_lit;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic set_digits(input logic [3:0][7:0] p);
    for (int i = 0; i < ND; i++) digits[i] = p[i];
  endtask

  task automatic tick();
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fd, e_rdy, lit, bnd, xfer;
    logic [7:0] din [4];
    logic [3:0] ein;
    logic [3:0] bin;
    int         slot, idx;
    if (reset) begin
      e_seg = 8'h00; e_dig = 4'hF; e_fd = 1'b0; e_rdy = 1'b0;
      @(posedge clock); #1;
      t = 0; m_pend = 1'b0; m_ready = 1'b0; m_bl = 0; m_en = 4'hF;
      for (int i = 0; i < ND; i++) m_act[i] = 8'h00;
    end else begin
      slot  = t % SD;
      idx   = (t / SD) % ND;
      lit   = (slot >= BL) && (((slot - BL) % (1 << BB)) < m_bl) && m_en[idx];
      e_seg = lit ? m_act[idx] : 8'h00;
      e_dig = lit ? ~(4'b0001 << idx) : 4'hF;
      bnd   = ((t % FRAME) == FRAME - 1);
      e_fd  = bnd;
      xfer  = update_valid && m_ready;
      for (int i = 0; i < ND; i++) din[i] = digits[i];
      ein = digit_enable;
      bin = brightness;
      @(posedge clock); #1;
      if (slot == 0) m_bl = int'(bin);
      if (bnd && m_pend) begin
        m_act = m_pbuf; m_en = m_pen; m_pend = 1'b0;
      end
      if (xfer) begin
        m_pbuf = din; m_pen = ein; m_pend = 1'b1;
      end
      m_ready = !m_pend;
      e_rdy   = m_ready;
      t++;
    end
    obs_seg = segment_out;
    obs_dig = digit_selector_out;
    obs_fd  = frame_done;
    obs_rdy = update_ready;
    chk("seg", obs_seg, e_seg);
    chk("dig", obs_dig, e_dig);
    chk("frame_done", obs_fd, e_fd);
    chk("ready", obs_rdy, e_rdy);
  endtask

  task automatic run_to(input int pos);
    int n = 0;
    while ((t % FRAME) != pos && n < 2 * FRAME) begin tick(); n++; end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!obs_rdy && n < 3 * FRAME) begin tick(); n++; end
    chk("ready_timeout", obs_rdy, 1);
  endtask

  task automatic send(input logic [3:0][7:0] p, input logic [3:0] en);
    wait_ready();
    set_digits(p);
    digit_enable = en;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    chk("ready_drop", obs_rdy, 0);
  endtask

  task automatic wait_applied();
    wait_ready();
    chk("fd_with_ready", obs_fd, 1);
  endtask

  // Expects the next tick to show slot 0 of digit 0.
  task automatic count_frame(input logic [3:0][7:0] p, output logic [3:0][7:0] cnt);
    logic [3:0] want;
    int d;
    cnt = '0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      d = k / SD;
      if (obs_dig != 4'hF) begin
        cnt[d] = cnt[d] + 8'd1;
        want = ~(4'b0001 << d);
        chk("frame_dig", obs_dig, want);
        chk("frame_seg", obs_seg, p[d]);
      end
    end
  endtask

  logic [3:0][7:0] cnt;
  logic [3:0][7:0] pat_a, pat_b, pat_c, pat_d, pat_e;
  int              per;

  initial begin
    tbl[0] = '{pat: {8'h4F, 8'h5B, 8'h06, 8'h3F}, en: 4'hF,    br: 4'd15, exp_lit: {8'd27, 8'd27, 8'd27, 8'd27}};
    tbl[1] = '{pat: {8'h4F, 8'h5B, 8'h06, 8'h3F}, en: 4'hF,    br: 4'd0,  exp_lit: {8'd0,  8'd0,  8'd0,  8'd0}};
    tbl[2] = '{pat: {8'h4F, 8'h5B, 8'h06, 8'h3F}, en: 4'hF,    br: 4'd4,  exp_lit: {8'd8,  8'd8,  8'd8,  8'd8}};
    tbl[3] = '{pat: {8'h4F, 8'h5B, 8'h06, 8'h3F}, en: 4'b1010, br: 4'd15, exp_lit: {8'd27, 8'd0,  8'd27, 8'd0}};
    tbl[4] = '{pat: {8'h00, 8'h7E, 8'h81, 8'hFF}, en: 4'hF,    br: 4'd1,  exp_lit: {8'd2,  8'd2,  8'd2,  8'd2}};
    tbl[5] = '{pat: {8'h12, 8'h34, 8'h56, 8'h78}, en: 4'b0101, br: 4'd13, exp_lit: {8'd0,  8'd25, 8'd0,  8'd25}};
    pat_a = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    pat_b = {8'h07, 8'h7D, 8'h6D, 8'h66};
    pat_c = {8'hAA, 8'h55, 8'hF0, 8'h0F};
    pat_d = {8'h71, 8'h79, 8'h5E, 8'h39};
    pat_e = {8'hC3, 8'h3C, 8'h99, 8'h66};

    set_digits('0);
    digit_enable = 4'hF;
    update_valid = 1'b0;
    brightness   = 4'd0;
    reset        = 1'b1;
    t            = 0;

    repeat (3) tick();
    chk("rst_seg", obs_seg, 8'h00);
    chk("rst_dig", obs_dig, 4'hF);
    chk("rst_fd", obs_fd, 0);
    chk("rst_ready", obs_rdy, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", obs_rdy, 1);

    for (int r = 0; r < 6; r++) begin
      brightness = tbl[r].br;
      send(tbl[r].pat, tbl[r].en);
      wait_applied();
      count_frame(tbl[r].pat, cnt);
      for (int d = 0; d < ND; d++) chk($sformatf("lit_count_r%0d_d%0d", r, d), cnt[d], tbl[r].exp_lit[d]);
      chk("fd_end_of_frame", obs_fd, 1);
      per = 0;
      do begin tick(); per++; end while (!obs_fd && per < 2 * FRAME);
      chk("fd_period", per, FRAME);
    end

    // Update accepted mid-frame shows only from the next frame.
    brightness = 4'd15;
    send(pat_a, 4'hF);
    wait_applied();
    run_to(50);
    send(pat_b, 4'hF);
    wait_applied();
    count_frame(pat_b, cnt);
    chk("midframe_lit_d0", cnt[0], 27);

    // Offer held while busy is ignored.
    run_to(10);
    send(pat_a, 4'hF);
    set_digits(pat_c);
    update_valid = 1'b1;
    repeat (20) tick();
    chk("held_not_accepted", obs_rdy, 0);
    update_valid = 1'b0;
    wait_applied();
    count_frame(pat_a, cnt);
    chk("held_lit_d3", cnt[3], 27);

    // Transfer on the boundary cycle waits one more frame.
    run_to(FRAME - 1);
    set_digits(pat_d);
    digit_enable = 4'hF;
    update_valid = 1'b1;
    tick();
    update_valid = 1'b0;
    chk("bnd_fd", obs_fd, 1);
    chk("bnd_ready", obs_rdy, 0);
    count_frame(pat_a, cnt);
    wait_applied();
    count_frame(pat_d, cnt);
    chk("bnd_lit_d1", cnt[1], 27);

    // Reset mid-slot with an update pending.
    run_to(60);
    send(pat_e, 4'hF);
    run_to(2 * SD + 10);
    reset = 1'b1;
    tick();
    chk("rst_mid_seg", obs_seg, 8'h00);
    chk("rst_mid_dig", obs_dig, 4'hF);
    chk("rst_mid_fd", obs_fd, 0);
    chk("rst_mid_ready", obs_rdy, 0);
    reset = 1'b0;
    count_frame('0, cnt);
    for (int d = 0; d < ND; d++) chk("rst_restart_lit", cnt[d], 27);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 999) == 0);
      update_valid = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < ND; k++) digits[k] = 8'($urandom);
      digit_enable = 4'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom);
      tick();
    end
    reset = 1'b0;
    update_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
